// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 320x240x3 framebuffer, each stored pixel doubled in both axes.
// Optional colour-bar generator is built when VGA_TEST_PATTERN_EN is defined.
module vga_scanout #(
    parameter int unsigned CLOCK_DIV       = 2,
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33,
    parameter int unsigned FB_WIDTH        = 320,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] ram_address,
    input  logic [2:0]  ram_read_data,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start,
    output logic        in_vblank,
    input  logic        test_pattern
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // At least 10 bits so the colour-bar select hcount[9:7] always exists.
    localparam int unsigned HW   = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int unsigned VW   = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
    localparam int unsigned DivW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_W     = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_W     = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_START    = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END      = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_START    = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END      = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic          SYNC_IDLE   = (SYNC_ACTIVE_LOW != 0);

    logic pix_en;

    // ------------------------------------------------------------------
    // Pixel-rate enable
    // ------------------------------------------------------------------
    generate
        if (CLOCK_DIV == 1) begin : g_no_div
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam logic [DivW-1:0] DIV_LAST = DivW'(CLOCK_DIV - 1);
            logic [DivW-1:0] div_cnt_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    div_cnt_q <= '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_q <= '0;
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
            end

            assign pix_en = (div_cnt_q == DIV_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters and frame status
    // ------------------------------------------------------------------
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          frame_start_q, frame_start_d;
    logic          in_vblank_q, in_vblank_d;
    logic          h_wrap, v_wrap;

    assign h_wrap = (hcount_q == H_LAST);
    assign v_wrap = (vcount_q == V_LAST);

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (h_wrap) begin
                hcount_d = '0;
                vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
        frame_start_d = pix_en & h_wrap & v_wrap;
        // Tracks the line the counters are moving to, so it changes with them.
        in_vblank_d   = (vcount_d >= V_VIS_W);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            in_vblank_q   <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
            in_vblank_q   <= in_vblank_d;
        end
    end

    assign frame_start = frame_start_q;
    assign in_vblank   = in_vblank_q;

    // ------------------------------------------------------------------
    // Visible region, sync windows and framebuffer address
    // ------------------------------------------------------------------
    logic        active;
    logic        hsync_on;
    logic        vsync_on;
    logic [18:0] fb_x;
    logic [18:0] fb_y;
    logic [18:0] addr_sum;

    assign active   = (hcount_q < H_VIS_W) && (vcount_q < V_VIS_W);
    assign hsync_on = (hcount_q >= HS_START) && (hcount_q < HS_END);
    assign vsync_on = (vcount_q >= VS_START) && (vcount_q < VS_END);

    assign fb_x = 19'(hcount_q[HW-1:1]);
    assign fb_y = 19'(vcount_q[VW-1:1]);

    // Constant multiply by FB_WIDTH as a sum of shifted rows (320 -> y<<8 + y<<6).
    always_comb begin
        addr_sum = fb_x;
        for (int i = 0; i < 19; i++) begin
            if (FB_WIDTH[i]) begin
                addr_sum = addr_sum + (fb_y << i);
            end
        end
    end

    assign ram_address = active ? addr_sum : 19'd0;

    // ------------------------------------------------------------------
    // Stage 1: controls travel alongside the RAM read
    // ------------------------------------------------------------------
    logic active_q1;
    logic hsync_q1;
    logic vsync_q1;

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q1 <= 1'b0;
            hsync_q1  <= 1'b0;
            vsync_q1  <= 1'b0;
        end else begin
            active_q1 <= active;
            hsync_q1  <= hsync_on;
            vsync_q1  <= vsync_on;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers
    // ------------------------------------------------------------------
    logic [2:0] rgb_d, rgb_q;
    logic       hsync_pin_q, vsync_pin_q;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_q1;

    always_ff @(posedge clock) begin
        if (reset) begin
            bar_q1 <= 3'b000;
        end else begin
            bar_q1 <= hcount_q[9:7];
        end
    end

    always_comb begin
        rgb_d = 3'b000;
        if (active_q1) begin
            rgb_d = test_pattern ? bar_q1 : ram_read_data;
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;

    always_comb begin
        rgb_d = 3'b000;
        if (active_q1) begin
            rgb_d = ram_read_data;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q       <= 3'b000;
            hsync_pin_q <= SYNC_IDLE;
            vsync_pin_q <= SYNC_IDLE;
        end else begin
            rgb_q       <= rgb_d;
            hsync_pin_q <= hsync_q1 ? ~SYNC_IDLE : SYNC_IDLE;
            vsync_pin_q <= vsync_q1 ? ~SYNC_IDLE : SYNC_IDLE;
        end
    end

    assign vga_r     = rgb_q[2];
    assign vga_g     = rgb_q[1];
    assign vga_b     = rgb_q[0];
    assign vga_hsync = hsync_pin_q;
    assign vga_vsync = vsync_pin_q;

endmodule
